// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution: flag register, 4-entry target table, IDLE/RUN/FLUSH/DONE sequencing.
// Latency: taken branch presents the target on PC the cycle after the decision; Flush is high for that cycle.
// Backpressure: Stall freezes PC and state in any state; flag and table writes proceed regardless of Stall.
module branch_pc_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Halt,
  input  logic            Stall,
  input  logic            Zero,
  input  logic            Sign,
  input  logic            FlagWe,
  input  logic [1:0]      BrOp,
  input  logic [1:0]      imm,
  input  logic            LutWe,
  input  logic [1:0]      LutAddr,
  input  logic [PC_W-1:0] LutData,
  output logic [PC_W-1:0] PC,
  output logic            Flush,
  output logic            Running,
  output logic            Done,
  output logic            ZeroFlag,
  output logic            SignFlag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_ZERO = 2'b01;
  localparam logic [1:0] BR_SIGN = 2'b10;
  localparam logic [1:0] BR_JUMP = 2'b11;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            zero_flag_q;
  logic            sign_flag_q;
  logic [PC_W-1:0] lut_q [4];
  logic            br_taken;

  // Branch condition from the flag register as it stood at the start of the cycle (no write bypass).
  always_comb begin
    br_taken = 1'b0;
    case (BrOp)
      BR_NONE: br_taken = 1'b0;
      BR_ZERO: br_taken = zero_flag_q;
      BR_SIGN: br_taken = sign_flag_q;
      BR_JUMP: br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and next-PC selection; Stall holds everything, Halt beats any branch in RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!Stall) begin
      case (state_q)
        ST_IDLE: begin
          pc_d = START_ADDR;
          if (Start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (Halt) begin
            state_d = ST_DONE;
          end else if (br_taken) begin
            pc_d    = lut_q[imm];
            state_d = ST_FLUSH;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
        ST_FLUSH: begin
          pc_d    = pc_q + PC_ONE;
          state_d = ST_RUN;
        end
        ST_DONE: begin
          if (Start) begin
            pc_d    = START_ADDR;
            state_d = ST_RUN;
          end
        end
        default: begin
          pc_d    = START_ADDR;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and PC registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Flag register: captured whenever requested, independent of state and Stall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      zero_flag_q <= 1'b0;
      sign_flag_q <= 1'b0;
    end else if (FlagWe) begin
      zero_flag_q <= Zero;
      sign_flag_q <= Sign;
    end
  end

  // Branch target table: written whenever requested, independent of state and Stall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) begin
        lut_q[i] <= '0;
      end
    end else if (LutWe) begin
      lut_q[LutAddr] <= LutData;
    end
  end

  // Status outputs decoded purely from registered state so they carry no input paths.
  always_comb begin
    PC       = pc_q;
    Flush    = (state_q == ST_FLUSH);
    Running  = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    Done     = (state_q == ST_DONE);
    ZeroFlag = zero_flag_q;
    SignFlag = sign_flag_q;
  end

endmodule
